onehot_decoder_seq: RTL and testbench



---
 rtl/onehot_decoder_seq.sv | 143 ++++++++++++++
 tb/tb_onehot_decoder_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_decoder_seq.sv
// Registered N-to-2^N one-hot decoder with a dwell/sweep sequencer.
// Accepts one command at a time over valid/ready; out is one-hot while active, zero otherwise.
module onehot_decoder_seq #(
  parameter int unsigned N     = 3,
  parameter int unsigned DWELL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      sel,
  input  logic [1:0]        mode,
  input  logic [N:0]        len,
  output logic [2**N-1:0]   out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned OUTS = 2**N;
  localparam int unsigned DW   = $clog2(DWELL + 1);

  localparam logic [N:0] LenMax = {1'b1, {N{1'b0}}};

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StActive = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    idx_q, idx_d;
  logic            down_q, down_d;
  logic [N:0]      len_q, len_d;
  logic [N:0]      line_q, line_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [OUTS-1:0] out_q, out_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            accept;
  logic            is_sweep;
  logic [N:0]      len_eff;
  logic [N:0]      line_next;
  logic            dwell_last;

  assign in_ready   = (state_q != StActive);
  assign accept     = in_valid & in_ready & en;
  assign is_sweep   = (mode == 2'b01) || (mode == 2'b10);
  assign line_next  = line_q + (N+1)'(1);
  assign dwell_last = (dwell_q == DW'(DWELL - 1));

  // Single mode (00/11) always runs exactly one line; sweeps clamp 0 and oversize to OUTS.
  always_comb begin
    len_eff = (N+1)'(1);
    if (is_sweep) begin
      if (len == '0 || len > LenMax) begin
        len_eff = LenMax;
      end else begin
        len_eff = len;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    down_d  = down_q;
    len_d   = len_q;
    line_d  = line_q;
    dwell_d = dwell_q;

    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          state_d = StActive;
          idx_d   = sel;
          down_d  = (mode == 2'b10);
          len_d   = len_eff;
          line_d  = '0;
          dwell_d = '0;
        end
      end
      StActive: begin
        // With en low every counter holds, so the command resumes exactly where it paused.
        if (en) begin
          if (dwell_last) begin
            dwell_d = '0;
            line_d  = line_next;
            if (line_next == len_q) begin
              state_d = StDone;
            end else if (down_q) begin
              idx_d = idx_q - N'(1);
            end else begin
              idx_d = idx_q + N'(1);
            end
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from next state so they are registered without a cycle of lag.
  always_comb begin
    out_d = '0;
    if (state_d == StActive) begin
      out_d[idx_d] = 1'b1;
    end
    busy_d = (state_d == StActive);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      down_q  <= 1'b0;
      len_q   <= '0;
      line_q  <= '0;
      dwell_q <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      down_q  <= down_d;
      len_q   <= len_d;
      line_q  <= line_d;
      dwell_q <= dwell_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq: a vector table of commands with expected line
// sequences, plus hand-written reset, pause, back-to-back and N=2/DWELL=1 sequences.
module tb_onehot_decoder_seq;

  typedef struct packed {
    logic [2:0]  sel;
    logic [1:0]  mode;
    logic [3:0]  len;
    int          nlines;
    logic [63:0] lines;  // expected lines, first line in the top byte
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] sel;
  logic [1:0] mode;
  logic [3:0] len;
  logic [7:0] out;
  logic       busy;
  logic       done;

  logic       s_en;
  logic       s_in_valid;
  logic       s_in_ready;
  logic [1:0] s_sel;
  logic [1:0] s_mode;
  logic [2:0] s_len;
  logic [3:0] s_out;
  logic       s_busy;
  logic       s_done;

  int passed = 0;
  int total  = 0;

  vec_t vecs [7];

  onehot_decoder_seq #(.N(3), .DWELL(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .mode     (mode),
    .len      (len),
    .out      (out),
    .busy     (busy),
    .done     (done)
  );

  onehot_decoder_seq #(.N(2), .DWELL(1)) dut_small (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (s_en),
    .in_valid (s_in_valid),
    .in_ready (s_in_ready),
    .sel      (s_sel),
    .mode     (s_mode),
    .len      (s_len),
    .out      (s_out),
    .busy     (s_busy),
    .done     (s_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " idle out"}, 32'(out), 32'h0);
    check({tag, " idle busy"}, 32'(busy), 32'h0);
    check({tag, " idle done"}, 32'(done), 32'h0);
    check({tag, " idle in_ready"}, 32'(in_ready), 32'h1);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] exp;
    check({tag, " in_ready before accept"}, 32'(in_ready), 32'h1);
    in_valid = 1'b1;
    sel      = v.sel;
    mode     = v.mode;
    len      = v.len;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 2 * v.nlines; c++) begin
      exp = v.lines[63 - 8 * (c / 2) -: 8];
      check($sformatf("%s out cyc%0d", tag, c), 32'(out), 32'(exp));
      check($sformatf("%s busy cyc%0d", tag, c), 32'(busy), 32'h1);
      check($sformatf("%s done cyc%0d", tag, c), 32'(done), 32'h0);
      check($sformatf("%s in_ready cyc%0d", tag, c), 32'(in_ready), 32'h0);
      @(negedge clk);
    end
    check({tag, " done pulse"}, 32'(done), 32'h1);
    check({tag, " done out"}, 32'(out), 32'h0);
    check({tag, " done busy"}, 32'(busy), 32'h0);
    check({tag, " done in_ready"}, 32'(in_ready), 32'h1);
    @(negedge clk);
    check_idle(tag);
  endtask

  initial begin
    vecs[0] = '{sel: 3'd3, mode: 2'b00, len: 4'd5, nlines: 1,
                lines: {8'h08, 56'h0}};
    vecs[1] = '{sel: 3'd6, mode: 2'b01, len: 4'd4, nlines: 4,
                lines: {8'h40, 8'h80, 8'h01, 8'h02, 32'h0}};
    vecs[2] = '{sel: 3'd1, mode: 2'b10, len: 4'd0, nlines: 8,
                lines: {8'h02, 8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04}};
    vecs[3] = '{sel: 3'd7, mode: 2'b11, len: 4'd3, nlines: 1,
                lines: {8'h80, 56'h0}};
    vecs[4] = '{sel: 3'd0, mode: 2'b01, len: 4'd9, nlines: 8,
                lines: {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80}};
    vecs[5] = '{sel: 3'd5, mode: 2'b10, len: 4'd2, nlines: 2,
                lines: {8'h20, 8'h10, 48'h0}};
    vecs[6] = '{sel: 3'd2, mode: 2'b01, len: 4'd1, nlines: 1,
                lines: {8'h04, 56'h0}};

    rst_n      = 1'b0;
    en         = 1'b1;
    in_valid   = 1'b0;
    sel        = '0;
    mode       = '0;
    len        = '0;
    s_en       = 1'b1;
    s_in_valid = 1'b0;
    s_sel      = '0;
    s_mode     = '0;
    s_len      = '0;

    #1;
    check("reset out", 32'(out), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);
    check("reset in_ready", 32'(in_ready), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset mid-sweep, then accept on the very first edge after release.
    in_valid = 1'b1;
    sel      = 3'd0;
    mode     = 2'b01;
    len      = 4'd8;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out", 32'(out), 32'h0);
    check("async reset busy", 32'(busy), 32'h0);
    check("async reset in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      vec_t v;
      v = '{sel: 3'd5, mode: 2'b00, len: 4'd0, nlines: 1, lines: {8'h20, 56'h0}};
      run_vec(v, "post-reset");
    end

    // en low while idle blocks acceptance.
    en       = 1'b0;
    in_valid = 1'b1;
    sel      = 3'd4;
    mode     = 2'b00;
    repeat (2) begin
      @(negedge clk);
      check("en0 idle busy", 32'(busy), 32'h0);
      check("en0 idle out", 32'(out), 32'h0);
      check("en0 idle in_ready", 32'(in_ready), 32'h1);
    end
    en = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("en1 accept out", 32'(out), 32'h10);
    @(negedge clk);
    check("en1 second dwell", 32'(out), 32'h10);
    @(negedge clk);
    check("en1 done", 32'(done), 32'h1);
    @(negedge clk);
    check_idle("en1");

    // Pause during the second dwell cycle of line 4 in an up-sweep 3,4,5.
    in_valid = 1'b1;
    sel      = 3'd3;
    mode     = 2'b01;
    len      = 4'd3;
    @(negedge clk);
    in_valid = 1'b0;
    check("pause l3 c0", 32'(out), 32'h08);
    @(negedge clk);
    check("pause l3 c1", 32'(out), 32'h08);
    @(negedge clk);
    check("pause l4 c0", 32'(out), 32'h10);
    @(negedge clk);
    check("pause l4 c1", 32'(out), 32'h10);
    en = 1'b0;
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      check($sformatf("paused out %0d", p), 32'(out), 32'h10);
      check($sformatf("paused busy %0d", p), 32'(busy), 32'h1);
      check($sformatf("paused done %0d", p), 32'(done), 32'h0);
    end
    en = 1'b1;
    @(negedge clk);
    check("resume l5 c0", 32'(out), 32'h20);
    @(negedge clk);
    check("resume l5 c1", 32'(out), 32'h20);
    @(negedge clk);
    check("pause done", 32'(done), 32'h1);
    check("pause done out", 32'(out), 32'h0);
    @(negedge clk);
    check_idle("pause");

    // in_valid held high: the busy-time command waits and is taken in the DONE cycle.
    in_valid = 1'b1;
    sel      = 3'd2;
    mode     = 2'b00;
    @(negedge clk);
    check("b2b A c0", 32'(out), 32'h04);
    sel = 3'd6;
    @(negedge clk);
    check("b2b A c1 ignores B", 32'(out), 32'h04);
    @(negedge clk);
    check("b2b A done", 32'(done), 32'h1);
    check("b2b A done out", 32'(out), 32'h0);
    check("b2b A done in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    check("b2b B c0", 32'(out), 32'h40);
    check("b2b B done low", 32'(done), 32'h0);
    sel = 3'd2;
    @(negedge clk);
    check("b2b B c1", 32'(out), 32'h40);
    @(negedge clk);
    check("b2b B done", 32'(done), 32'h1);
    @(negedge clk);
    check("b2b A2 c0", 32'(out), 32'h04);
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b A2 c1", 32'(out), 32'h04);
    @(negedge clk);
    check("b2b A2 done", 32'(done), 32'h1);
    @(negedge clk);
    check_idle("b2b");

    // N=2, DWELL=1 full sweep.
    s_in_valid = 1'b1;
    s_sel      = 2'd0;
    s_mode     = 2'b01;
    s_len      = 3'd4;
    @(negedge clk);
    s_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] e;
      e = 4'b0001 << k;
      check($sformatf("small line %0d", k), 32'(s_out), 32'(e));
      check($sformatf("small busy %0d", k), 32'(s_busy), 32'h1);
      @(negedge clk);
    end
    check("small done", 32'(s_done), 32'h1);
    check("small done out", 32'(s_out), 32'h0);
    @(negedge clk);
    check("small idle done", 32'(s_done), 32'h0);
    check("small idle ready", 32'(s_in_ready), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
